// File: rtl/codebook_b3_f_decoder.sv
// Bit-serial decoder for the terminating codewords of flush codebook 3.
// Optional handshake counter enabled by CODEBOOK_B3_F_DECODER_STATS_EN.
module codebook_b3_f_decoder #(
    parameter int CODEBOOK_LENGTH_MAX = 64,
    parameter int ENCODE_DATALENGTH   = 21
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           clear_i,
    input  logic                           bit_i,
    input  logic                           bit_valid_i,
    output logic                           bit_ready_o,
    output logic                           out_valid_o,
    input  logic                           out_ready_i,
    output logic [5:0]                     ap_cnt_o,
    output logic [CODEBOOK_LENGTH_MAX-1:0] ap_data_o,
    output logic [5:0]                     cw_length_o,
    output logic [ENCODE_DATALENGTH-1:0]   cw_data_o,
    output logic                           err_o
`ifdef CODEBOOK_B3_F_DECODER_STATS_EN
    ,
    output logic [15:0]                    cw_count_o
`endif
);

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        HOLD    = 2'd1,
        ERR     = 2'd2
    } state_t;

    state_t state, state_next;

    logic [ENCODE_DATALENGTH-2:0] sr;
    logic [5:0]                   cnt;
    logic [ENCODE_DATALENGTH-1:0] cand;
    logic [5:0]                   n;
    logic                         accept;
    logic                         hit;
    logic [5:0]                   m_cnt;
    logic [15:0]                  m_data;

    assign cand   = {sr, bit_i};
    assign n      = cnt + 6'd1;
    assign accept = (state == COLLECT) && bit_valid_i;

    assign bit_ready_o = (state == COLLECT);
    assign out_valid_o = (state == HOLD);
    assign err_o       = (state == ERR);

    // Only entries whose length equals the bit count are eligible, so upper
    // candidate bits never need masking.
    always_comb begin
        hit    = 1'b0;
        m_cnt  = '0;
        m_data = '0;
        case (n)
            6'd6: begin
                if (cand[5:0] == 6'b101000) begin
                    hit = 1'b1; m_cnt = 6'd1; m_data = 16'h000F;
                end
            end
            6'd8: begin
                case (cand[7:0])
                    8'b11010110: begin hit = 1'b1; m_cnt = 6'd2; m_data = 16'h000F; end
                    8'b11011001: begin hit = 1'b1; m_cnt = 6'd2; m_data = 16'h002F; end
                    default: ;
                endcase
            end
            6'd9: begin
                case (cand[8:0])
                    9'b111011110: begin hit = 1'b1; m_cnt = 6'd2; m_data = 16'h003F; end
                    9'b111100101: begin hit = 1'b1; m_cnt = 6'd3; m_data = 16'h000F; end
                    default: ;
                endcase
            end
            6'd10: begin
                if (cand[9:0] == 10'b1111101100) begin
                    hit = 1'b1; m_cnt = 6'd2; m_data = 16'h004F;
                end
            end
            6'd11: begin
                case (cand[10:0])
                    11'b11111101100: begin hit = 1'b1; m_cnt = 6'd3; m_data = 16'h021F; end
                    11'b11111101101: begin hit = 1'b1; m_cnt = 6'd3; m_data = 16'h022F; end
                    default: ;
                endcase
            end
            6'd12: begin
                case (cand[11:0])
                    12'b111111110100: begin hit = 1'b1; m_cnt = 6'd2; m_data = 16'h006F; end
                    12'b111111110101: begin hit = 1'b1; m_cnt = 6'd3; m_data = 16'h023F; end
                    12'b111111110110: begin hit = 1'b1; m_cnt = 6'd3; m_data = 16'h031F; end
                    12'b111111110111: begin hit = 1'b1; m_cnt = 6'd3; m_data = 16'h032F; end
                    12'b111111111000: begin hit = 1'b1; m_cnt = 6'd3; m_data = 16'h041F; end
                    12'b111111111001: begin hit = 1'b1; m_cnt = 6'd4; m_data = 16'h001F; end
                    12'b111111111010: begin hit = 1'b1; m_cnt = 6'd4; m_data = 16'h002F; end
                    default: ;
                endcase
            end
            6'd13: begin
                case (cand[12:0])
                    13'b1111111111110: begin hit = 1'b1; m_cnt = 6'd4; m_data = 16'h211F; end
                    13'b1111111111111: begin hit = 1'b1; m_cnt = 6'd4; m_data = 16'h221F; end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= COLLECT;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            COLLECT: begin
                if (bit_valid_i) begin
                    if (hit) begin
                        state_next = HOLD;
                    end else if (n == 6'd13) begin
                        state_next = ERR;
                    end
                end
            end
            HOLD: begin
                if (out_ready_i) begin
                    state_next = COLLECT;
                end
            end
            ERR:     state_next = ERR;
            default: state_next = COLLECT;
        endcase
        if (clear_i) begin
            state_next = COLLECT;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            sr  <= '0;
            cnt <= '0;
        end else if (accept) begin
            if (hit || (n == 6'd13)) begin
                sr  <= '0;
                cnt <= '0;
            end else begin
                sr  <= cand[ENCODE_DATALENGTH-2:0];
                cnt <= n;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ap_cnt_o    <= '0;
            ap_data_o   <= '0;
            cw_length_o <= '0;
            cw_data_o   <= '0;
        end else if (accept && hit && !clear_i) begin
            ap_cnt_o    <= m_cnt;
            ap_data_o   <= {{(CODEBOOK_LENGTH_MAX-16){1'b0}}, m_data};
            cw_length_o <= n;
            cw_data_o   <= cand;
        end
    end

`ifdef CODEBOOK_B3_F_DECODER_STATS_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cw_count_o <= '0;
        end else if (out_valid_o && out_ready_i) begin
            cw_count_o <= cw_count_o + 16'd1;
        end
    end
`endif

endmodule
